// File: rtl/z80_bus_seq.sv
// z80_bus_seq: Z80 bus-cycle sequencer (memory, I/O, M1 fetch with refresh, interrupt acknowledge)
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   req_i/req_ready_o               request handshake; command fields req_io_i, req_wr_i, req_m1_i,
//                                   req_addr_i, req_wdata_i are latched on accept
//   rfsh_page_i                     upper refresh address byte (I register)
//   ack_o, rdata_o                  completion pulse and latched read/vector data
//   a_o, dout_o, dout_en_o, din_i   external address and data bus
//   wait_n_i                        external wait request
//   m1_n_o .. rfsh_n_o              active-low bus strobes
module z80_bus_seq #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter bit T2WRITE  = 1,
    parameter bit REFRESH  = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_i,
    output logic          req_ready_o,
    input  logic          req_io_i,
    input  logic          req_wr_i,
    input  logic          req_m1_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [7:0]    rfsh_page_i,
    output logic          ack_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] a_o,
    output logic [DW-1:0] dout_o,
    output logic          dout_en_o,
    input  logic [DW-1:0] din_i,
    input  logic          wait_n_i,
    output logic          m1_n_o,
    output logic          mreq_n_o,
    output logic          iorq_n_o,
    output logic          rd_n_o,
    output logic          wr_n_o,
    output logic          rfsh_n_o
);
    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

    state_t        state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic [6:0]    rcnt_q, rcnt_d;
    logic          io_q, io_d, wr_q, wr_d, m1_q, m1_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          ready_q, ready_d, ack_q, ack_d, den_q, den_d;
    logic          m1n_q, m1n_d, mreqn_q, mreqn_d, iorqn_q, iorqn_d;
    logic          rdn_q, rdn_d, wrn_q, wrn_d, rfshn_q, rfshn_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] dout_q, dout_d, rdata_q, rdata_d;

    logic accept, fetch_q, wrc_q, fetch_d, intack_d, wrc_d, mid, rfsh_ph;

    assign accept  = req_i && state_q == IDLE;
    assign fetch_q = m1_q && !io_q;
    assign wrc_q   = wr_q && !m1_q;

    // Command is captured on accept so the output logic can already use it for T1.
    assign io_d    = accept ? req_io_i    : io_q;
    assign wr_d    = accept ? req_wr_i    : wr_q;
    assign m1_d    = accept ? req_m1_i    : m1_q;
    assign addr_d  = accept ? req_addr_i  : addr_q;
    assign wdata_d = accept ? req_wdata_i : wdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            io_q    <= 1'b0;
            wr_q    <= 1'b0;
            m1_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            io_q    <= io_d;
            wr_q    <= wr_d;
            m1_q    <= m1_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Mandatory waits are counted down first; wait_n only extends once the counter is empty.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: state_d = accept ? T1 : IDLE;
            T1: begin
                state_d = T2;
                wcnt_d  = io_q ? 3'(IO_WAIT) : 3'(MEM_WAIT);
            end
            T2, TW: begin
                state_d = (wcnt_q != 3'd0 || !wait_n_i) ? TW : T3;
                wcnt_d  = (wcnt_q != 3'd0) ? wcnt_q - 3'd1 : wcnt_q;
            end
            T3: state_d = (fetch_q && REFRESH) ? T4 : IDLE;
            T4: begin
                state_d = IDLE;
                rcnt_d  = rcnt_q + 7'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and registered, so they line up with it.
    assign fetch_d  = m1_d && !io_d;
    assign intack_d = m1_d && io_d;
    assign wrc_d    = wr_d && !m1_d;
    assign mid      = state_d inside {T2, TW};
    assign rfsh_ph  = fetch_d && REFRESH && state_d inside {T3, T4};

    always_comb begin
        m1n_d   = !(m1_d && (state_d == T1 || mid || (state_d == T3 && !rfsh_ph)));
        mreqn_d = !(!io_d && (mid || state_d == T3));
        iorqn_d = !(io_d && (intack_d ? state_d == TW : (mid || state_d == T3)));
        rdn_d   = !(!wrc_d && !intack_d && (mid || (state_d == T3 && !rfsh_ph)));
        wrn_d   = !(wrc_d && (state_d inside {TW, T3} || (state_d == T2 && T2WRITE)));
        rfshn_d = !rfsh_ph;
        a_d     = rfsh_ph ? AW'({rfsh_page_i, 1'b0, rcnt_q})
                : (state_d inside {T1, T2, TW, T3}) ? addr_d : a_q;
        den_d   = wrc_d && state_d inside {T1, T2, TW, T3};
        dout_d  = den_d ? wdata_d : dout_q;
        ack_d   = state_d == IDLE && state_q != IDLE;
        ready_d = state_d == IDLE;
        rdata_d = (state_q inside {T2, TW} && state_d == T3 && !wrc_q) ? din_i : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            den_q   <= 1'b0;
            m1n_q   <= 1'b1;
            mreqn_q <= 1'b1;
            iorqn_q <= 1'b1;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            rfshn_q <= 1'b1;
            a_q     <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
        end else begin
            ready_q <= ready_d;
            ack_q   <= ack_d;
            den_q   <= den_d;
            m1n_q   <= m1n_d;
            mreqn_q <= mreqn_d;
            iorqn_q <= iorqn_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            rfshn_q <= rfshn_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready_o = ready_q;
    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign a_o         = a_q;
    assign dout_o      = dout_q;
    assign dout_en_o   = den_q;
    assign m1_n_o      = m1n_q;
    assign mreq_n_o    = mreqn_q;
    assign iorq_n_o    = iorqn_q;
    assign rd_n_o      = rdn_q;
    assign wr_n_o      = wrn_q;
    assign rfsh_n_o    = rfshn_q;
endmodule

// File: tb/tb_z80_bus_seq.sv
// tb_z80_bus_seq: self-checking bench for z80_bus_seq with an rdata scoreboard
module tb_z80_bus_seq;
    localparam int MEM_W = 0;
    localparam int IO_W  = 1;

    logic        clk = 1'b0;
    logic        reset_n, req, req_ready, req_io, req_wr, req_m1;
    logic [15:0] req_addr, a;
    logic [7:0]  req_wdata, rfsh_page, rdata, dout, din;
    logic        ack, dout_en, wait_n;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;

    int          total = 0;
    int          bad = 0;
    logic [6:0]  rc = '0;
    logic [7:0]  last_rd = '0;
    logic [7:0]  sb[$];

    always #5 clk = ~clk;

    z80_bus_seq #(.AW(16), .DW(8), .MEM_WAIT(MEM_W), .IO_WAIT(IO_W), .T2WRITE(1'b0), .REFRESH(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req), .req_ready_o(req_ready),
        .req_io_i(req_io), .req_wr_i(req_wr), .req_m1_i(req_m1),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rfsh_page_i(rfsh_page),
        .ack_o(ack), .rdata_o(rdata), .a_o(a), .dout_o(dout), .dout_en_o(dout_en),
        .din_i(din), .wait_n_i(wait_n),
        .m1_n_o(m1_n), .mreq_n_o(mreq_n), .iorq_n_o(iorq_n), .rd_n_o(rd_n),
        .wr_n_o(wr_n), .rfsh_n_o(rfsh_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 fetch, 5 int-ack
    // s: 1 T1, 2 T2, 3 TW, 4 T3, 5 T4
    task automatic chk_state(input int kind, input int s, input logic [15:0] addr, input logic [7:0] wd);
        logic m1l, mreql, iorql, rdl, wrl, rfl, den;
        logic [15:0] ea;
        m1l = 0; mreql = 0; iorql = 0; rdl = 0; wrl = 0; rfl = 0; den = 0;
        ea = addr;
        case (kind)
            0: begin mreql = s inside {2, 3, 4}; rdl = mreql; end
            1: begin mreql = s inside {2, 3, 4}; wrl = s inside {3, 4}; den = s inside {1, 2, 3, 4}; end
            2: begin iorql = s inside {2, 3, 4}; rdl = iorql; end
            3: begin iorql = s inside {2, 3, 4}; wrl = s inside {3, 4}; den = s inside {1, 2, 3, 4}; end
            4: begin
                m1l = s inside {1, 2, 3}; mreql = s inside {2, 3, 4}; rdl = s inside {2, 3};
                rfl = s inside {4, 5};
                if (s >= 4) ea = {rfsh_page, 1'b0, rc};
            end
            default: begin m1l = s inside {1, 2, 3, 4}; iorql = s == 3; end
        endcase
        chk($sformatf("bus k%0d s%0d", kind, s), {25'd0, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, dout_en},
            {25'd0, !m1l, !mreql, !iorql, !rdl, !wrl, !rfl, den});
        chk($sformatf("addr k%0d s%0d", kind, s), {16'd0, a}, {16'd0, ea});
        chk($sformatf("ack k%0d s%0d", kind, s), {31'd0, ack}, 32'd0);
        if (den) chk("dout", {24'd0, dout}, {24'd0, wd});
    endtask

    // Drives one request (at a negedge while the DUT is idle) and follows it through to its ack cycle.
    task automatic run(input int kind, input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] dv, input int extw);
        logic io, wr;
        int mw, nw;
        io = kind inside {2, 3, 5};
        wr = kind inside {1, 3};
        mw = io ? IO_W : MEM_W;
        nw = mw + extw;
        if (!wr) last_rd = dv;
        sb.push_back(last_rd);
        req = 1; req_io = io; req_wr = wr || kind == 4; req_m1 = kind >= 4;
        req_addr = addr; req_wdata = wd; din = ~dv; wait_n = 1;
        @(posedge clk);
        #1 req = 0; req_addr = ~addr; req_wdata = ~wd; req_io = ~io; req_m1 = 0;
        @(negedge clk);
        chk_state(kind, 1, addr, wd);
        @(posedge clk);
        for (int k = 0; k <= nw; k++) begin
            @(negedge clk);
            chk_state(kind, k == 0 ? 2 : 3, addr, wd);
            wait_n = !(k >= mw && k < nw);
            din = wait_n ? dv : ~dv;
            @(posedge clk);
            #1 wait_n = 1; din = ~dv;
        end
        @(negedge clk);
        chk_state(kind, 4, addr, wd);
        if (kind == 4) begin
            @(posedge clk);
            @(negedge clk);
            chk_state(kind, 5, addr, wd);
            rc = rc + 7'd1;
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("ack_end k%0d", kind), {30'd0, ack, req_ready}, 32'd3);
        chk($sformatf("idle_bus k%0d", kind), {25'd0, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, dout_en}, 32'h7E);
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else chk($sformatf("rdata k%0d", kind), {24'd0, rdata}, {24'd0, sb.pop_front()});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bus"}, {25'd0, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, dout_en}, 32'h7E);
        chk({tag, "_a"}, {16'd0, a}, 32'd0);
        chk({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
        chk({tag, "_ready_ack"}, {30'd0, req_ready, ack}, 32'd2);
        chk({tag, "_dout"}, {24'd0, dout}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 0; req = 1; req_io = 0; req_wr = 0; req_m1 = 0;
        req_addr = 16'h1234; req_wdata = 8'h00; rfsh_page = 8'h3F; din = 8'hFF; wait_n = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        req = 0;
        @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("post_reset");

        run(0, 16'h1234, 8'h00, 8'h5A, 0);
        run(3, 16'h00FE, 8'hA5, 8'h00, 0);
        run(1, 16'h8001, 8'h3C, 8'h00, 0);
        run(2, 16'h0010, 8'h00, 8'hC3, 0);
        run(0, 16'h4000, 8'h00, 8'h99, 3);
        run(3, 16'h0011, 8'h77, 8'h00, 2);
        @(posedge clk);
        @(negedge clk);
        chk("ack_one_cycle", {30'd0, ack, req_ready}, 32'd1);
        run(5, 16'h00FF, 8'h00, 8'hE7, 0);
        for (int i = 0; i < 130; i++) run(4, 16'h0100 + 16'(i * 3), 8'h00, 8'(i) ^ 8'h55, 0);
        chk("rcnt_wrapped", {25'd0, rc}, 32'd2);

        // reset while an I/O read sits in its mandatory TW
        req = 1; req_io = 1; req_wr = 0; req_m1 = 0; req_addr = 16'h0042; din = 8'h24; wait_n = 1;
        @(posedge clk);
        #1 req = 0;
        @(posedge clk);
        @(negedge clk);
        wait_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_tw_iorq", {31'd0, iorq_n}, 32'd0);
        reset_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("mid_reset");
        reset_n = 1; wait_n = 1; rc = '0; last_rd = '0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_no_ack", {31'd0, ack}, 32'd0);
        run(0, 16'h2222, 8'h00, 8'h11, 1);
        run(4, 16'h0555, 8'h00, 8'hAB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
